pulse_bank: RTL
===============

# pulse_bank

Multi-channel programmable pulse generator: `CHANNELS` independent strobe generators share one clock. Each channel produces one-cycle pulses every N input cycles (periodic) or a single pulse N cycles after a trigger (one-shot). Divider N and mode are loaded at runtime without glitches. It is the next generation of the fixed-ratio divider and supplies baud ticks, scan strobes and timeouts to the rest of the lab designs.

## Interface

Parameters:

- `CHANNELS`, 4 — number of independent channels (1..16).
- `WIDTH`, 16 — divider/counter width per channel; max N = 2^WIDTH−1.
- `DEFAULT_DIV`, 10 — divider value every channel holds after reset.
- `DEFAULT_MODE`, 0 — mode after reset (0 = periodic, 1 = one-shot).

Ports:

- `CLK_IN` input 1 — single clock; all logic on its rising edge.
- `RST_N` input 1 — synchronous, active-low reset.
- `EN_IN` input CHANNELS — per-channel enable, level.
- `LOAD_IN` input CHANNELS — per-channel strobe: request load of `DIV_IN`/`MODE_IN` slice.
- `DIV_IN` input CHANNELS*WIDTH — divider values; channel k uses bits [k*WIDTH +: WIDTH].
- `MODE_IN` input CHANNELS — mode to load; bit k for channel k.
- `TRIG_IN` input CHANNELS — one-shot start strobe.
- `PULSE_OUT` output CHANNELS — registered one-cycle pulses.
- `BUSY_OUT` output CHANNELS — one-shot countdown in progress.

## Operation

- Each channel holds the following state:
  - active divider `div` (WIDTH bits)
  - active mode `mode`
  - shadow divider and shadow mode
  - `pend` flag
  - counter `cnt` (WIDTH bits)
  - `run` flag
- Reset (`RST_N`=0 at an edge) sets every output to 0, `cnt`=0, `run`=0, `pend`=0, `div`=DEFAULT_DIV, `mode`=DEFAULT_MODE. Reset dominates all other inputs.
- Load:
  - `LOAD_IN[k]` captures the `DIV_IN`/`MODE_IN` slice into the shadow registers and sets `pend`.
  - A pending config transfers to active when the channel is idle (`run`=0 or `EN_IN[k]`=0) or on the cycle `cnt` wraps. It is never applied mid-period.
  - A second LOAD before transfer overwrites the shadow; only the last value is applied.
- Count step while `EN_IN[k]`=1 and `run`=1:
  - If `cnt == div−1`: `cnt`←0 and `PULSE_OUT[k]`←1.
  - Otherwise: `cnt`←`cnt`+1 and `PULSE_OUT[k]`←0.
- Periodic mode (mode=0): `run` is forced to 1 whenever `EN_IN[k]`=1 and `div`≠0.
- One-shot mode (mode=1):
  - `TRIG_IN[k]` with EN=1 and `run`=0 sets `run`=1, `cnt`=0, and `BUSY_OUT[k]`=1.
  - On the terminal count: pulse, then `run`=0 and `BUSY_OUT`=0 in the same edge.
  - A TRIG while `run`=1 is ignored (no restart).
- `EN_IN[k]`=0: next edge clears `cnt`, `run`, `PULSE_OUT[k]` and `BUSY_OUT[k]`. Shadow and `pend` are kept. Disabling mid-count aborts a one-shot with no pulse.
- `div`=0: channel is inert. No pulses, `run` stays 0, and TRIG is ignored.
- `div`=1, periodic: `PULSE_OUT` stays high every cycle while enabled, starting 1 cycle after EN.
- Channels are fully independent. A load, trigger or enable on one channel never affects another.

## Timing

- Periodic: EN rises before edge 0 (cnt=0). The first `PULSE_OUT` is high after edge N, then every N edges, each pulse exactly 1 cycle wide (N≥2).
- One-shot: TRIG sampled at edge 0. `BUSY_OUT` is high from edge 0 through edge N. `PULSE_OUT` is high for the cycle after edge N, and `BUSY_OUT` is low in that same cycle.
- Config transfer happens at the wrap edge, so the period following a pulse already uses the new divider. LOAD on the wrap edge itself applies to the next period.
- Load while idle: the new `div` is active one edge after LOAD.
- All outputs are registered with no combinational input-to-output paths.

## Structure

- Package `pulse_pkg`: mode constants `MODE_PERIODIC`=1'b0 and `MODE_ONESHOT`=1'b1, plus the channel-slice index helper.
- Sub-module `pulse_chan`: one channel, parametrised by WIDTH/DEFAULT_DIV/DEFAULT_MODE. `pulse_bank` is a generate loop of `CHANNELS` instances plus port slicing.

## Test plan

- Reset defaults: `DEFAULT_DIV`=10. Enable ch0 periodic → pulses at edges 10, 20, 30. All outputs are 0 during reset and one edge after reset.
- Glitch-free reload: ch1 periodic at div=8, then LOAD div=3 at edge 5 → pulse at edge 8, then at 11 and 14. No pulse at 3 or 6.
- One-shot: ch2 mode=1 div=5, TRIG at edge 0 → `BUSY` high for edges 0–5, single pulse after edge 5. A TRIG at edge 2 is ignored. A second TRIG at edge 7 gives a pulse after edge 12.
- Abort/disable: ch3 one-shot div=6 triggered, EN dropped at edge 3 → no pulse and `BUSY`=0 after edge 4. Periodic disable mid-period restarts the count from 0 on re-enable.
- Boundary dividers: div=0 → no pulses or busy for 50 cycles. div=1 periodic → `PULSE_OUT` constant 1. div=2^WIDTH−1 → period exactly 65535.
- Channel independence and mid-op reset: four channels at div 2, 3, 5, 7 show no cross-coupling. `RST_N` low at an arbitrary edge → all counters restart and reload `DEFAULT_DIV`.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared mode encodings and bus-slicing helper for the pulse_bank channels.
package pulse_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  function automatic int chan_lo(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/pulse_chan.sv
// One strobe channel: periodic or one-shot divider with shadowed, glitch-free reload.
// Registered outputs; a pending config lands only while idle or on the wrap edge.
module pulse_chan
  import pulse_pkg::*;
#(
  parameter int   WIDTH        = 16,
  parameter int   DEFAULT_DIV  = 10,
  parameter logic DEFAULT_MODE = MODE_PERIODIC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] new_div,
  input  logic             new_mode,
  input  logic             trig,
  output logic             pulse,
  output logic             busy
);

  logic [WIDTH-1:0] div, div_nxt, sh_div, sh_div_nxt, cnt, cnt_nxt;
  logic             mode, mode_nxt, sh_mode, sh_mode_nxt;
  logic             pend, pend_nxt, run, run_nxt, pulse_nxt, busy_nxt;
  logic             wrap;

  assign wrap = en && run && (div != '0) && (cnt == div - WIDTH'(1));

  always_comb begin
    cnt_nxt     = cnt;
    run_nxt     = run;
    pulse_nxt   = 1'b0;
    busy_nxt    = busy;
    div_nxt     = div;
    mode_nxt    = mode;
    sh_div_nxt  = sh_div;
    sh_mode_nxt = sh_mode;
    pend_nxt    = pend;

    if (!en) begin
      cnt_nxt  = '0;
      run_nxt  = 1'b0;
      busy_nxt = 1'b0;
    end else if (run) begin
      if (wrap) begin
        cnt_nxt   = '0;
        pulse_nxt = 1'b1;
        if (mode == MODE_ONESHOT) begin
          run_nxt  = 1'b0;
          busy_nxt = 1'b0;
        end
      end else begin
        cnt_nxt = cnt + WIDTH'(1);
      end
    end else if (div != '0) begin
      if (mode == MODE_PERIODIC) begin
        run_nxt = 1'b1;
        cnt_nxt = '0;
      end else if (trig) begin
        run_nxt  = 1'b1;
        cnt_nxt  = '0;
        busy_nxt = 1'b1;
      end
    end

    // A mode change or zero divider cancels whatever the old config just started.
    if (pend && (!en || !run || wrap)) begin
      div_nxt  = sh_div;
      mode_nxt = sh_mode;
      pend_nxt = 1'b0;
      if (sh_div == '0 || sh_mode != mode) begin
        run_nxt  = 1'b0;
        busy_nxt = 1'b0;
      end
    end

    if (load) begin
      sh_div_nxt  = new_div;
      sh_mode_nxt = new_mode;
      pend_nxt    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div     <= WIDTH'(DEFAULT_DIV);
      mode    <= DEFAULT_MODE;
      sh_div  <= WIDTH'(DEFAULT_DIV);
      sh_mode <= DEFAULT_MODE;
      pend    <= 1'b0;
      cnt     <= '0;
      run     <= 1'b0;
      pulse   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      div     <= div_nxt;
      mode    <= mode_nxt;
      sh_div  <= sh_div_nxt;
      sh_mode <= sh_mode_nxt;
      pend    <= pend_nxt;
      cnt     <= cnt_nxt;
      run     <= run_nxt;
      pulse   <= pulse_nxt;
      busy    <= busy_nxt;
    end
  end

endmodule

// File: rtl/pulse_bank.sv
// Bank of independent programmable pulse generators on one clock.
// One pulse_chan per channel; outputs registered, no flow control.
module pulse_bank
  import pulse_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int WIDTH        = 16,
  parameter int DEFAULT_DIV  = 10,
  parameter int DEFAULT_MODE = 0
) (
  input  logic                      CLK_IN,
  input  logic                      RST_N,
  input  logic [CHANNELS-1:0]       EN_IN,
  input  logic [CHANNELS-1:0]       LOAD_IN,
  input  logic [CHANNELS*WIDTH-1:0] DIV_IN,
  input  logic [CHANNELS-1:0]       MODE_IN,
  input  logic [CHANNELS-1:0]       TRIG_IN,
  output logic [CHANNELS-1:0]       PULSE_OUT,
  output logic [CHANNELS-1:0]       BUSY_OUT
);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    pulse_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV),
      .DEFAULT_MODE(1'(DEFAULT_MODE))
    ) u_chan (
      .clk     (CLK_IN),
      .rst_n   (RST_N),
      .en      (EN_IN[k]),
      .load    (LOAD_IN[k]),
      .new_div (DIV_IN[chan_lo(k, WIDTH) +: WIDTH]),
      .new_mode(MODE_IN[k]),
      .trig    (TRIG_IN[k]),
      .pulse   (PULSE_OUT[k]),
      .busy    (BUSY_OUT[k])
    );
  end

endmodule
